// File: rtl/handshake_constant_check_pkg.sv
// Shared handshake definitions: skid-buffer state encoding and a
// width-parameterised saturating increment used by the debug counters.
package handshake_constant_check_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } hs_state_t;

    localparam int SAT_MAX_W = 64;

    // Callers zero-extend their counter into SAT_MAX_W bits and slice the
    // result back down; width selects the saturation point.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] all_ones;
        if (width >= SAT_MAX_W) begin
            all_ones = '1;
        end else begin
            all_ones = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        end
        if (value >= all_ones) begin
            sat_inc = all_ones;
        end else begin
            sat_inc = value + SAT_MAX_W'(1);
        end
    endfunction

endpackage

// File: rtl/handshake_skid_1b.sv
// Two-entry, full-throughput skid buffer carrying a 1-bit payload.
// All outputs, including in_ready, come straight from flops.
module handshake_skid_1b
    import handshake_constant_check_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_match,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic out_match
);

    hs_state_t state_reg;
    logic      main_match_reg;
    logic      skid_match_reg;
    logic      in_ready_reg;
    logic      out_valid_reg;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_EMPTY;
            main_match_reg <= 1'b0;
            skid_match_reg <= 1'b0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    in_ready_reg <= 1'b1;
                    if (in_fire) begin
                        state_reg      <= ST_ONE;
                        main_match_reg <= in_match;
                        out_valid_reg  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_match_reg <= in_match;
                        in_ready_reg   <= 1'b1;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new token in skid.
                        state_reg      <= ST_TWO;
                        skid_match_reg <= in_match;
                        in_ready_reg   <= 1'b0;
                    end else if (out_fire) begin
                        state_reg     <= ST_EMPTY;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_reg      <= ST_ONE;
                        main_match_reg <= skid_match_reg;
                        in_ready_reg   <= 1'b1;
                    end else begin
                        in_ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_match = main_match_reg;

endmodule

// File: rtl/handshake_constant_check.sv
// Handshake sink that compares each token against CONST_VALUE and emits a
// dataless match token, with saturating debug counters and a sticky error.
module handshake_constant_check
    import handshake_constant_check_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(7'b0111001),
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic                  ctrl_match,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  token_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  err_sticky
);

    logic                 match;
    logic                 in_fire;
    logic                 ins_ready_int;
    logic [CNT_WIDTH-1:0] token_count_reg;
    logic [CNT_WIDTH-1:0] mismatch_count_reg;
    logic                 err_sticky_reg;

    assign match   = (ins == CONST_VALUE);
    assign in_fire = ins_valid & ins_ready_int;

    handshake_skid_1b u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ins_valid),
        .in_match  (match),
        .in_ready  (ins_ready_int),
        .out_valid (ctrl_valid),
        .out_ready (ctrl_ready),
        .out_match (ctrl_match)
    );

    // clr restarts the counters from this cycle's token contribution so a
    // token accepted alongside clr is never lost from the statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            token_count_reg    <= '0;
            mismatch_count_reg <= '0;
            err_sticky_reg     <= 1'b0;
        end else if (clr) begin
            token_count_reg    <= in_fire ? CNT_WIDTH'(1) : '0;
            mismatch_count_reg <= (in_fire && !match) ? CNT_WIDTH'(1) : '0;
            err_sticky_reg     <= in_fire && !match;
        end else if (in_fire) begin
            token_count_reg <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(token_count_reg), CNT_WIDTH));
            if (!match) begin
                mismatch_count_reg <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(mismatch_count_reg), CNT_WIDTH));
                err_sticky_reg     <= 1'b1;
            end
        end
    end

    assign ins_ready      = ins_ready_int;
    assign token_count    = token_count_reg;
    assign mismatch_count = mismatch_count_reg;
    assign err_sticky     = err_sticky_reg;

endmodule

// File: doc/handshake_constant_check.md
Name: handshake_constant_check

Overview:
- Dataflow handshake sink and checker; the consuming counterpart of the constant-source blocks.
- Accepts data tokens on an elastic input channel and compares each against a compile-time constant.
- Emits one dataless control token per accepted input, carrying a match flag. A registered, full-throughput 2-entry skid stage sits between input and output.
- Keeps saturating token and mismatch counters plus a sticky error flag for debug readout.

Parameters:
DATA_WIDTH, 32, width of input data channel
CONST_VALUE, 57 (7'b0111001, zero-extended to DATA_WIDTH), expected token value
CNT_WIDTH, 16, width of token_count and mismatch_count

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
ins  input  DATA_WIDTH  input data token
ins_valid  input  1  input token valid
ins_ready  output  1  input ready, driven directly from a flop
ctrl_valid  output  1  output control token valid
ctrl_ready  input  1  downstream ready
ctrl_match  output  1  1 if the presented token equalled CONST_VALUE
clr  input  1  synchronous clear of counters and err_sticky
token_count  output  CNT_WIDTH  accepted input tokens, saturating
mismatch_count  output  CNT_WIDTH  accepted tokens with ins != CONST_VALUE, saturating
err_sticky  output  1  set on the first mismatch, held until clr or reset

Behaviour:
- Transfers: input fires when ins_valid & ins_ready. Output fires when ctrl_valid & ctrl_ready.
- Comparison: match = (ins == CONST_VALUE), full DATA_WIDTH equality. Evaluated only on input fire.
- Storage: main entry (valid, match) and skid entry (valid, match). No data is stored, only the match bit.
- State machine:
  - EMPTY: main and skid empty.
  - ONE: main full.
  - TWO: main and skid full.
- Transitions:
  - EMPTY + in fire -> ONE.
  - ONE + in fire, no out fire -> TWO (new token goes to skid).
  - ONE + in fire + out fire -> ONE (main replaced).
  - ONE + out fire only -> EMPTY.
  - TWO + out fire -> ONE (skid moves to main).
  - In fire is impossible in TWO.
- Outputs: ctrl_valid = main valid. ctrl_match = main match. Both are stable while ctrl_valid & !ctrl_ready; the token must not change before it is accepted.
- ins_ready flop: next value = 1 unless the next state is TWO.
- Latency: one cycle from input fire to ctrl_valid. Throughput is one token per cycle while ctrl_ready=1.
- Backpressure: in ONE, with ctrl_ready=0 and an input firing, the token enters skid and ins_ready drops the following cycle. No token is lost or duplicated.
- Counters, on input fire:
  - token_count += 1.
  - mismatch_count += 1 if !match.
  - err_sticky <= 1 if !match.
  - Both counters saturate at all-ones and never wrap.
- clr in the same cycle as an input fire: counters load 0 + this token's contribution, i.e. token_count=1, mismatch_count=!match, err_sticky=!match. clr does not affect handshake state.
- Reset (rst low, asynchronous):
  - State -> EMPTY; ins_ready=0, ctrl_valid=0, ctrl_match=0.
  - Counters = 0, err_sticky=0.
  - ins_ready rises on the first clk edge after rst deasserts.
  - Reset mid-operation discards buffered tokens.
- ins and ctrl_ready are ignored while rst is low.

Decomposition:
- Shared handshake package holds:
  - the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2)
  - a saturating-increment function parameterised by width
- One natural sub-module: handshake_skid_1b, a 2-entry skid buffer for a 1-bit payload. The checker instantiates it and adds the comparator and counters.

Test Plan:
- Reset release, ctrl_ready=1, stream 57,57,3 on consecutive cycles -> ctrl_valid for 3 consecutive cycles, each one cycle after its input fire; ctrl_match=1,1,0; token_count=3, mismatch_count=1, err_sticky=1.
- ctrl_ready=0, present 57 then 5 -> ins_ready=0 from the cycle after the 2nd fire; ctrl_match held at 1. Raise ctrl_ready -> outputs 1 then 0; ins_ready returns to 1.
- Random ins_valid/ctrl_ready (50%), 1000 tokens, 10% non-57 -> output count and match sequence equal the input sequence; counters equal the reference model.
- CNT_WIDTH=4, 20 mismatching tokens -> token_count=15, mismatch_count=15, no wrap.
- clr asserted with an accepted token of value 9 -> token_count=1, mismatch_count=1, err_sticky=1. clr with no token -> all 0.
- rst low while in TWO -> ctrl_valid=0 and ins_ready=0 immediately, counters 0. After release, the first token 57 -> single output with ctrl_match=1.
